// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write-bus path: the 9-bit FIFO word
// layout, DC encodings and the bus-writer state encoding.
package lcd_pkg;

  // FIFO word: DC flag on top of the 8-bit payload.
  typedef struct packed {
    logic       dc;
    logic [7:0] payload;
  } lcd_word_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WR_LOW,
    WR_HIGH
  } wr_state_t;

  // Largest of three phase lengths; sizes the phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that measures one bus phase. Loading N makes done
// high on the Nth cycle after the load (the last cycle of the phase).
module lcd_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Reload on phase entry, otherwise count down and park at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value - 1'b1;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// Drains the LCD command/pixel FIFO onto an 8080-style write bus.
// Back-to-back words are streamed under a single CS# assertion.
// Optional feature: define LCD_BYTE_COUNT_EN to build the 32-bit counter of
// words written; without it byte_count is tied to zero.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [8:0]  fifo_rdata,
  input  logic        fifo_rempty,
  output logic        fifo_rinc,
  output logic        lcd_cs_n,
  output logic        lcd_dc,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic [31:0] byte_count
);

  localparam int MAX_CYCLES = max3(SETUP_CYCLES, WR_LOW_CYCLES, WR_HIGH_CYCLES);
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  wr_state_t       state, next_state;
  logic            capture;
  logic            timer_load;
  logic            timer_done;
  logic [TW-1:0]   timer_value;
  lcd_word_t       head;

  assign head = lcd_word_t'(fifo_rdata);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; capture marks the cycle a FIFO word is taken.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_rempty) begin
          capture    = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP:  if (timer_done) next_state = WR_LOW;
      WR_LOW: if (timer_done) next_state = WR_HIGH;
      WR_HIGH: begin
        if (timer_done) begin
          if (enable && !fifo_rempty) begin
            capture    = 1'b1;
            next_state = SETUP;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Phase length of the state being entered; loaded on every transition.
  always_comb begin
    timer_value = TW'(SETUP_CYCLES);
    case (next_state)
      WR_LOW:  timer_value = TW'(WR_LOW_CYCLES);
      WR_HIGH: timer_value = TW'(WR_HIGH_CYCLES);
      default: timer_value = TW'(SETUP_CYCLES);
    endcase
  end

  assign timer_load = (next_state != state);

  lcd_phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // Registered bus outputs, decoded from the state being entered so pin
  // changes line up exactly with the state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_rinc <= 1'b0;
      lcd_cs_n  <= 1'b1;
      lcd_wr_n  <= 1'b1;
      lcd_dc    <= DC_CMD;
      lcd_data  <= 8'h00;
    end else begin
      fifo_rinc <= capture;
      lcd_cs_n  <= (next_state == IDLE);
      lcd_wr_n  <= (next_state != WR_LOW);
      if (capture) begin
        lcd_dc   <= head.dc;
        lcd_data <= head.payload;
      end
    end
  end

  assign lcd_rd_n = 1'b1;
  assign busy     = (state != IDLE);

`ifdef LCD_BYTE_COUNT_EN
  logic [31:0] count;

  // One count per WR# rising edge; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (state == WR_LOW && next_state == WR_HIGH) begin
      count <= count + 32'd1;
    end
  end

  assign byte_count = count;
`else
  assign byte_count = 32'd0;
`endif

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: cycle-accurate vector table for single
// and burst writes, plus hand sequences for reset, enable drop, alternate
// phase timing and the optional word counter.
module tb_lcd_bus_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic [8:0]  fifo_rdata = 9'h0;
  logic        fifo_rempty = 1'b1;

  logic        rinc_a, cs_a, dc_a, wr_a, rd_a, busy_a;
  logic [7:0]  data_a;
  logic [31:0] count_a;
  logic        rinc_b, cs_b, dc_b, wr_b, rd_b, busy_b;
  logic [7:0]  data_b;
  logic [31:0] count_b;

  int n_vec = 0;
  int n_bad = 0;
  int rinc_empty = 0;
  int rinc_a_cnt = 0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  lcd_bus_writer dut_a (
    .clk(clk), .rst(rst), .enable(en_a),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(rinc_a),
    .lcd_cs_n(cs_a), .lcd_dc(dc_a), .lcd_wr_n(wr_a), .lcd_rd_n(rd_a),
    .lcd_data(data_a), .busy(busy_a), .byte_count(count_a)
  );

  lcd_bus_writer #(
    .SETUP_CYCLES(2), .WR_LOW_CYCLES(3), .WR_HIGH_CYCLES(1)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(en_b),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(rinc_b),
    .lcd_cs_n(cs_b), .lcd_dc(dc_b), .lcd_wr_n(wr_b), .lcd_rd_n(rd_b),
    .lcd_data(data_b), .busy(busy_b), .byte_count(count_b)
  );

  // FWFT FIFO model shared by both writers; only one is enabled at a time.
  function automatic void refresh();
    fifo_rempty = (q.size() == 0);
    fifo_rdata  = (q.size() > 0) ? q[0] : 9'h0;
  endfunction

  task automatic push(input logic [8:0] w);
    q.push_back(w);
    refresh();
  endtask

  always @(posedge clk) begin
    if (rinc_a || rinc_b) begin
      if (q.size() > 0) void'(q.pop_front());
      else rinc_empty++;
    end
    if (rinc_a) rinc_a_cnt++;
    #1 refresh();
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic       push;
    logic [8:0] word;
    logic       cs_n;
    logic       wr_n;
    logic       dc;
    logic [7:0] data;
    logic       rinc;
    logic       busy;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(input logic en, input logic p, input logic [8:0] w,
                              input logic cs, input logic wr, input logic dc,
                              input logic [7:0] d, input logic ri, input logic bz);
    vec_t v;
    v.en = en; v.push = p; v.word = w; v.cs_n = cs; v.wr_n = wr;
    v.dc = dc; v.data = d; v.rinc = ri; v.busy = bz;
    return v;
  endfunction

  initial begin
    int cs_low, wr_low, wr_run, wr_run_max, r0, r1, guard;
    logic [31:0] exp_count;

    // Single command 0x2C
    vecs[0]  = mk(1, 1, 9'h02C, 0, 1, 0, 8'h2C, 1, 1);
    vecs[1]  = mk(1, 0, 9'h000, 0, 0, 0, 8'h2C, 0, 1);
    vecs[2]  = mk(1, 0, 9'h000, 0, 0, 0, 8'h2C, 0, 1);
    vecs[3]  = mk(1, 0, 9'h000, 0, 1, 0, 8'h2C, 0, 1);
    vecs[4]  = mk(1, 0, 9'h000, 0, 1, 0, 8'h2C, 0, 1);
    vecs[5]  = mk(1, 0, 9'h000, 1, 1, 0, 8'h2C, 0, 0);
    vecs[6]  = mk(1, 0, 9'h000, 1, 1, 0, 8'h2C, 0, 0);
    // Burst 2C, 1AA, 155 under one CS#
    vecs[7]  = mk(1, 1, 9'h02C, 0, 1, 0, 8'h2C, 1, 1);
    vecs[8]  = mk(1, 1, 9'h1AA, 0, 0, 0, 8'h2C, 0, 1);
    vecs[9]  = mk(1, 1, 9'h155, 0, 0, 0, 8'h2C, 0, 1);
    vecs[10] = mk(1, 0, 9'h000, 0, 1, 0, 8'h2C, 0, 1);
    vecs[11] = mk(1, 0, 9'h000, 0, 1, 0, 8'h2C, 0, 1);
    vecs[12] = mk(1, 0, 9'h000, 0, 1, 1, 8'hAA, 1, 1);
    vecs[13] = mk(1, 0, 9'h000, 0, 0, 1, 8'hAA, 0, 1);
    vecs[14] = mk(1, 0, 9'h000, 0, 0, 1, 8'hAA, 0, 1);
    vecs[15] = mk(1, 0, 9'h000, 0, 1, 1, 8'hAA, 0, 1);
    vecs[16] = mk(1, 0, 9'h000, 0, 1, 1, 8'hAA, 0, 1);
    vecs[17] = mk(1, 0, 9'h000, 0, 1, 1, 8'h55, 1, 1);
    vecs[18] = mk(1, 0, 9'h000, 0, 0, 1, 8'h55, 0, 1);
    vecs[19] = mk(1, 0, 9'h000, 0, 0, 1, 8'h55, 0, 1);
    vecs[20] = mk(1, 0, 9'h000, 0, 1, 1, 8'h55, 0, 1);
    vecs[21] = mk(1, 0, 9'h000, 0, 1, 1, 8'h55, 0, 1);
    vecs[22] = mk(1, 0, 9'h000, 1, 1, 1, 8'h55, 0, 0);
    // enable low with a word waiting, then released
    vecs[23] = mk(0, 1, 9'h0FF, 1, 1, 1, 8'h55, 0, 0);
    vecs[24] = mk(0, 0, 9'h000, 1, 1, 1, 8'h55, 0, 0);
    vecs[25] = mk(1, 0, 9'h000, 0, 1, 0, 8'hFF, 1, 1);
    vecs[26] = mk(1, 0, 9'h000, 0, 0, 0, 8'hFF, 0, 1);
    vecs[27] = mk(1, 0, 9'h000, 0, 0, 0, 8'hFF, 0, 1);
    vecs[28] = mk(1, 0, 9'h000, 0, 1, 0, 8'hFF, 0, 1);
    vecs[29] = mk(1, 0, 9'h000, 0, 1, 0, 8'hFF, 0, 1);
    vecs[30] = mk(1, 0, 9'h000, 1, 1, 0, 8'hFF, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {cs_a, wr_a, rd_a, dc_a, data_a, rinc_a, busy_a},
          {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    check("reset_count", count_a, 32'd0);

    // Vector table
    for (int i = 0; i < 31; i++) begin
      en_a = vecs[i].en;
      if (vecs[i].push) push(vecs[i].word);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), {cs_a, wr_a, dc_a, data_a, rinc_a, busy_a},
            {vecs[i].cs_n, vecs[i].wr_n, vecs[i].dc, vecs[i].data,
             vecs[i].rinc, vecs[i].busy});
    end
    en_a = 1'b0;

    // Enable dropped during word 1 of 3
    r0 = rinc_a_cnt;
    push(9'h011); push(9'h122); push(9'h133);
    en_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_a = 1'b0;
    repeat (10) @(negedge clk);
    check("enable_drop_pops", rinc_a_cnt - r0, 1);
    check("enable_drop_left", q.size(), 2);
    check("enable_drop_idle", {cs_a, busy_a, data_a}, {1'b1, 1'b0, 8'h11});
    q.delete();
    refresh();

    // Reset asserted mid-WR_LOW
    push(9'h1C3);
    en_a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_wr_low", {cs_a, wr_a, busy_a}, {1'b0, 1'b0, 1'b1});
    #1 rst = 1'b1;
    #1;
    check("async_reset", {cs_a, wr_a, busy_a, rinc_a, dc_a, data_a},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    en_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    refresh();
    @(negedge clk);

    // Alternate timing: SETUP=2, WR_LOW=3, WR_HIGH=1 -> 6-clock period
    push(9'h101); push(9'h102);
    en_b = 1'b1;
    cs_low = 0; wr_low = 0; wr_run = 0; wr_run_max = 0; r0 = -1; r1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!cs_b) cs_low++;
      if (!wr_b) begin
        wr_low++;
        wr_run++;
        if (wr_run > wr_run_max) wr_run_max = wr_run;
      end else begin
        wr_run = 0;
      end
      if (rinc_b) begin
        if (r0 < 0) r0 = i;
        else r1 = i;
      end
    end
    en_b = 1'b0;
    check("alt_cs_low", cs_low, 12);
    check("alt_wr_low_total", wr_low, 6);
    check("alt_wr_low_run", wr_run_max, 3);
    check("alt_period", r1 - r0, 6);
    check("alt_last_word", {busy_b, dc_b, data_b}, {1'b0, 1'b1, 8'h02});

    // Word counter over 300 data words
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) push({1'b1, 8'(i)});
    en_a = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end while ((q.size() != 0 || busy_a) && guard < 2000);
    en_a = 1'b0;
    check("count_timeout", guard < 2000, 1'b1);
`ifdef LCD_BYTE_COUNT_EN
    exp_count = 32'd300;
`else
    exp_count = 32'd0;
`endif
    check("byte_count", count_a, exp_count);
    check("last_data_word", {dc_a, data_a, cs_a}, {1'b1, 8'h2B, 1'b1});
    check("no_rinc_when_empty", rinc_empty, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
